// File: rtl/car_motion_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : car_motion_sequencer
//  Description : Debounces the line-tracker code into a motion command, maps
//                it to per-wheel speed/direction targets, ramps each wheel
//                toward its target (through zero on reversal), handles the
//                obstacle emergency stop and drives the motor PWM pins.
//  Revision    : 1.0 - initial release
// ============================================================================
module car_motion_sequencer #(
    parameter int         HOLD_CYCLES = 4,
    parameter int         RAMP_DIV    = 1000,
    parameter int         RAMP_STEP   = 16,
    parameter logic [9:0] FAST        = 10'd800,
    parameter logic [9:0] SLOW        = 10'd500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       obstacle,
    input  logic [2:0] track_state,
    output logic       left_pwm,
    output logic       right_pwm,
    output logic       left_dir,
    output logic       right_dir,
    output logic [9:0] left_speed,
    output logic [9:0] right_speed,
    output logic [2:0] cmd,
    output logic [1:0] motion_state,
    output logic       moving
);

    localparam int              HOLD_W   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES - 1);
    localparam int              DIV_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_MAX  = DIV_W'(RAMP_DIV - 1);
    localparam logic [10:0]     STEP11   = 11'(RAMP_STEP);

    localparam logic [2:0] CODE_STOP         = 3'd0;
    localparam logic [2:0] CODE_FORWARD      = 3'd1;
    localparam logic [2:0] CODE_BACK         = 3'd2;
    localparam logic [2:0] CODE_LEFT         = 3'd3;
    localparam logic [2:0] CODE_RIGHT        = 3'd4;
    localparam logic [2:0] CODE_STRONG_LEFT  = 3'd5;
    localparam logic [2:0] CODE_STRONG_RIGHT = 3'd6;
    localparam logic [2:0] CODE_INVALID      = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        ESTOP = 2'd2
    } state_t;

    state_t            state, next_state;
    logic [2:0]        candidate;
    logic [HOLD_W-1:0] hold;
    logic [DIV_W-1:0]  prescaler;
    logic              tick;
    logic [9:0]        pwm_count;
    logic [9:0]        target_left, target_right;
    logic              target_dir_left, target_dir_right;
    logic              force_stop;

    // One ramp step for a wheel; returns {dir, speed}. A pending reversal
    // first drains the speed to zero, then flips the direction on its own tick.
    function automatic logic [10:0] ramp_next(input logic [9:0] spd, input logic dir,
                                              input logic [9:0] tgt, input logic tdir);
        logic [10:0] s11, t11, up, result;
        s11    = {1'b0, spd};
        t11    = {1'b0, tgt};
        up     = s11 + STEP11;
        result = {dir, spd};
        if (tdir != dir) begin
            if (spd != 10'd0)
                result = {dir, (s11 > STEP11) ? 10'(s11 - STEP11) : 10'd0};
            else
                result = {tdir, spd};
        end else if (s11 < t11) begin
            result = {dir, (up > t11) ? tgt : up[9:0]};
        end else if (s11 > t11) begin
            result = {dir, (s11 >= t11 + STEP11) ? 10'(s11 - STEP11) : tgt};
        end
        return result;
    endfunction

    // Debounce: a code must be seen unchanged for HOLD_CYCLES samples before it becomes cmd.
    always_ff @(posedge clk) begin
        if (reset) begin
            candidate <= 3'd0;
            hold      <= '0;
            cmd       <= CODE_STOP;
        end else begin
            if (track_state != candidate) begin
                candidate <= track_state;
                hold      <= '0;
            end else if (hold != HOLD_MAX) begin
                hold <= hold + HOLD_W'(1);
            end
            if (hold == HOLD_MAX)
                cmd <= (candidate == CODE_INVALID) ? CODE_STOP : candidate;
        end
    end

    // Motion state register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Motion next-state logic; obstacle overrides everything.
    always_comb begin
        next_state = state;
        if (obstacle)                      next_state = ESTOP;
        else if (state == ESTOP)           next_state = IDLE;
        else if (state == IDLE && enable)  next_state = RUN;
        else if (state == RUN && !enable)  next_state = IDLE;
    end

    // Per-wheel targets; only RUN drives nonzero speeds, reverse only for BACK.
    always_comb begin
        target_left      = 10'd0;
        target_right     = 10'd0;
        target_dir_left  = 1'b1;
        target_dir_right = 1'b1;
        if (state == RUN) begin
            case (cmd)
                CODE_FORWARD:      begin target_left = FAST; target_right = FAST; end
                CODE_BACK:         begin
                    target_left      = SLOW;
                    target_right     = SLOW;
                    target_dir_left  = 1'b0;
                    target_dir_right = 1'b0;
                end
                CODE_LEFT:         begin target_left = SLOW; target_right = FAST; end
                CODE_RIGHT:        begin target_left = FAST; target_right = SLOW; end
                CODE_STRONG_LEFT:  begin target_left = 10'd0; target_right = FAST; end
                CODE_STRONG_RIGHT: begin target_left = FAST; target_right = 10'd0; end
                default:           begin target_left = 10'd0; target_right = 10'd0; end
            endcase
        end
    end

    assign tick       = (prescaler == DIV_MAX);
    assign force_stop = obstacle || (state == ESTOP);

    // Ramp prescaler, free-running so command changes never restart it.
    always_ff @(posedge clk) begin
        if (reset)     prescaler <= '0;
        else if (tick) prescaler <= '0;
        else           prescaler <= prescaler + DIV_W'(1);
    end

    // Wheel speed/direction: immediate zero on emergency stop, otherwise ramp on ticks.
    always_ff @(posedge clk) begin
        if (reset) begin
            left_speed  <= 10'd0;
            right_speed <= 10'd0;
            left_dir    <= 1'b1;
            right_dir   <= 1'b1;
        end else if (force_stop) begin
            left_speed  <= 10'd0;
            right_speed <= 10'd0;
        end else if (tick) begin
            {left_dir, left_speed}   <= ramp_next(left_speed, left_dir, target_left, target_dir_left);
            {right_dir, right_speed} <= ramp_next(right_speed, right_dir, target_right, target_dir_right);
        end
    end

    // PWM generation from a free-running 10-bit counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_count <= 10'd0;
            left_pwm  <= 1'b0;
            right_pwm <= 1'b0;
        end else begin
            pwm_count <= pwm_count + 10'd1;
            left_pwm  <= (pwm_count < left_speed);
            right_pwm <= (pwm_count < right_speed);
        end
    end

    assign motion_state = state;
    assign moving       = (left_speed != 10'd0) || (right_speed != 10'd0);

endmodule
`default_nettype wire

// File: tb/tb_car_motion_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_car_motion_sequencer
//  Description : Self-checking bench for car_motion_sequencer with a
//                behavioural reference model and directed/random scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_car_motion_sequencer;

    localparam int         HOLD  = 4;
    localparam int         RD    = 3;
    localparam int         STEP  = 16;
    localparam logic [9:0] FASTV = 10'd800;
    localparam logic [9:0] SLOWV = 10'd500;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       obstacle = 1'b0;
    logic [2:0] track = 3'd0;
    logic       left_pwm, right_pwm, left_dir, right_dir, moving;
    logic [9:0] left_speed, right_speed;
    logic [2:0] cmd;
    logic [1:0] motion_state;

    int errors = 0;
    int checks = 0;

    car_motion_sequencer #(
        .HOLD_CYCLES(HOLD), .RAMP_DIV(RD), .RAMP_STEP(STEP), .FAST(FASTV), .SLOW(SLOWV)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .obstacle(obstacle),
        .track_state(track),
        .left_pwm(left_pwm), .right_pwm(right_pwm),
        .left_dir(left_dir), .right_dir(right_dir),
        .left_speed(left_speed), .right_speed(right_speed),
        .cmd(cmd), .motion_state(motion_state), .moving(moving)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Edge index since reset, start edge of the current run of identical
    // tracker samples, and plain-integer wheel state.
    int m_e, m_runval, m_runstart, m_cmd, m_st;
    int m_sl, m_sr, m_dl, m_dr, m_pl, m_pr;

    function automatic int tgt_speed(int st, int c, bit right);
        int tl[7] = '{0, FASTV, SLOWV, SLOWV, FASTV, 0, FASTV};
        int tr[7] = '{0, FASTV, SLOWV, FASTV, SLOWV, FASTV, 0};
        if (st != 1) return 0;
        return right ? tr[c] : tl[c];
    endfunction

    function automatic int tgt_dir(int st, int c);
        return (st == 1 && c == 2) ? 0 : 1;
    endfunction

    function automatic int ramp_spd(int s, int d, int t, int td);
        if (td != d) return (s > 0) ? ((s > STEP) ? s - STEP : 0) : s;
        if (s < t)   return (s + STEP > t) ? t : s + STEP;
        if (s > t)   return (s - STEP < t) ? t : s - STEP;
        return s;
    endfunction

    function automatic int ramp_dir(int s, int d, int td);
        return (td != d && s == 0) ? td : d;
    endfunction

    function automatic int next_state(int st, logic obs, logic en);
        if (obs)              return 2;
        if (st == 2)          return 0;
        if (st == 0 && en)    return 1;
        if (st == 1 && !en)   return 0;
        return st;
    endfunction

    // Model advances on every clock edge from the pre-edge model state.
    always @(posedge clk) begin
        if (reset) begin
            m_e <= 0; m_runval <= 0; m_runstart <= 0; m_cmd <= 0; m_st <= 0;
            m_sl <= 0; m_sr <= 0; m_dl <= 1; m_dr <= 1; m_pl <= 0; m_pr <= 0;
        end else begin
            m_e <= m_e + 1;
            if (m_e + 1 - m_runstart >= HOLD) m_cmd <= (m_runval == 7) ? 0 : m_runval;
            if (int'(track) != m_runval) begin
                m_runval   <= int'(track);
                m_runstart <= m_e + 1;
            end
            m_st <= next_state(m_st, obstacle, enable);
            m_pl <= ((m_e % 1024) < m_sl) ? 1 : 0;
            m_pr <= ((m_e % 1024) < m_sr) ? 1 : 0;
            if (obstacle || m_st == 2) begin
                m_sl <= 0; m_sr <= 0;
            end else if (m_e % RD == RD - 1) begin
                m_sl <= ramp_spd(m_sl, m_dl, tgt_speed(m_st, m_cmd, 0), tgt_dir(m_st, m_cmd));
                m_dl <= ramp_dir(m_sl, m_dl, tgt_dir(m_st, m_cmd));
                m_sr <= ramp_spd(m_sr, m_dr, tgt_speed(m_st, m_cmd, 1), tgt_dir(m_st, m_cmd));
                m_dr <= ramp_dir(m_sr, m_dr, tgt_dir(m_st, m_cmd));
            end
        end
    end

    logic [29:0] obs_v, exp_v;
    assign obs_v = {left_pwm, right_pwm, left_dir, right_dir, left_speed, right_speed,
                    cmd, motion_state, moving};
    assign exp_v = {m_pl[0], m_pr[0], m_dl[0], m_dr[0], 10'(m_sl), 10'(m_sr),
                    3'(m_cmd), 2'(m_st), (m_sl != 0 || m_sr != 0)};

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; obstacle = 1'b0; track = 3'd0;
        repeat (2) @(negedge clk);
        checks++;
        if ({left_speed, right_speed} !== 20'd0) begin
            errors++; $display("FAIL reset_speed got %h expected 0", {left_speed, right_speed});
        end
        checks++;
        if ({left_dir, right_dir, left_pwm, right_pwm} !== 4'b1100) begin
            errors++; $display("FAIL reset_dir_pwm got %b expected 1100", {left_dir, right_dir, left_pwm, right_pwm});
        end
        checks++;
        if ({cmd, motion_state, moving} !== 6'd0) begin
            errors++; $display("FAIL reset_cmd_state got %h expected 0", {cmd, motion_state, moving});
        end
        reset = 1'b0;
    endtask

    task automatic test_debounce();
        enable = 1'b1; track = 3'd1;
        repeat (3) begin
            @(negedge clk); checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL debounce_model got %h expected %h", obs_v, exp_v); end
        end
        track = 3'd0;
        repeat (6) begin
            @(negedge clk); checks++;
            if (cmd !== 3'd0) begin errors++; $display("FAIL debounce_short got %0d expected 0", cmd); end
        end
        track = 3'd1;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk); checks++;
            // observation i follows edge t+i-1, so cmd switches at observation HOLD+1
            if (cmd !== ((i >= HOLD + 1) ? 3'd1 : 3'd0)) begin
                errors++; $display("FAIL debounce_latency obs %0d got %0d expected %0d", i, cmd, (i >= HOLD + 1) ? 1 : 0);
            end
        end
    endtask

    task automatic test_ramp_clamp();
        int prev_l, before_final;
        track = 3'd3;
        prev_l = left_speed; before_final = -1;
        repeat (220) begin
            @(negedge clk); checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL ramp_model got %h expected %h", obs_v, exp_v); end
            if (int'(left_speed) != prev_l) begin
                if (left_speed == SLOWV) before_final = prev_l;
                prev_l = left_speed;
            end
        end
        checks++;
        if (left_speed !== SLOWV || right_speed !== FASTV) begin
            errors++; $display("FAIL ramp_final got %0d/%0d expected 500/800", left_speed, right_speed);
        end
        checks++;
        if (before_final != 496) begin
            errors++; $display("FAIL ramp_clamp got %0d expected 496", before_final);
        end
    endtask

    task automatic test_reversal();
        int downs, prev_l, flip_speed;
        bit flipped;
        track = 3'd1;
        repeat (250) @(negedge clk);
        checks++;
        if (left_speed !== FASTV || left_dir !== 1'b1) begin
            errors++; $display("FAIL rev_start got %0d dir %b expected 800 dir 1", left_speed, left_dir);
        end
        track = 3'd2;
        downs = 0; prev_l = left_speed; flipped = 0; flip_speed = -1;
        repeat (400) begin
            @(negedge clk); checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL rev_model got %h expected %h", obs_v, exp_v); end
            if (!flipped && int'(left_speed) < prev_l) downs++;
            if (!flipped && left_dir == 1'b0) begin flipped = 1; flip_speed = left_speed; end
            prev_l = left_speed;
        end
        checks++;
        if (downs != 50) begin errors++; $display("FAIL rev_downticks got %0d expected 50", downs); end
        checks++;
        if (flip_speed != 0) begin errors++; $display("FAIL rev_flip_speed got %0d expected 0", flip_speed); end
        checks++;
        if (left_speed !== SLOWV || left_dir !== 1'b0 || right_dir !== 1'b0) begin
            errors++; $display("FAIL rev_final got %0d dir %b%b expected 500 dir 00", left_speed, left_dir, right_dir);
        end
    endtask

    task automatic test_estop();
        track = 3'd1;
        repeat (300) @(negedge clk);
        checks++;
        if (left_speed !== FASTV) begin errors++; $display("FAIL estop_pre got %0d expected 800", left_speed); end
        obstacle = 1'b1;
        @(negedge clk); checks++;
        if ({left_speed, right_speed, motion_state, moving} !== {20'd0, 2'd2, 1'b0}) begin
            errors++; $display("FAIL estop_entry got %0d/%0d st %0d mv %b expected 0/0 st 2 mv 0",
                               left_speed, right_speed, motion_state, moving);
        end
        @(negedge clk); checks++;
        if ({left_pwm, right_pwm} !== 2'b00) begin errors++; $display("FAIL estop_pwm got %b expected 00", {left_pwm, right_pwm}); end
        obstacle = 1'b0;
        @(negedge clk); checks++;
        if (motion_state !== 2'd0) begin errors++; $display("FAIL estop_release got %0d expected 0", motion_state); end
        @(negedge clk); checks++;
        if (motion_state !== 2'd1) begin errors++; $display("FAIL estop_rerun got %0d expected 1", motion_state); end
        repeat (20) begin
            @(negedge clk); checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL estop_model got %h expected %h", obs_v, exp_v); end
        end
        checks++;
        if (left_speed > 10'd112) begin errors++; $display("FAIL estop_ramp got %0d expected <=112", left_speed); end
    endtask

    task automatic test_pwm_duty();
        int hl, hr;
        track = 3'd3;
        repeat (300) @(negedge clk);
        hl = 0; hr = 0;
        repeat (1024) begin @(negedge clk); hl += left_pwm; hr += right_pwm; end
        checks++;
        if (hl != 500 || hr != 800) begin errors++; $display("FAIL pwm_duty got %0d/%0d expected 500/800", hl, hr); end
        enable = 1'b0;
        repeat (300) @(negedge clk);
        hl = 0; hr = 0;
        repeat (1024) begin @(negedge clk); hl += left_pwm; hr += right_pwm; end
        checks++;
        if (hl != 0 || hr != 0) begin errors++; $display("FAIL pwm_zero got %0d/%0d expected 0/0", hl, hr); end
    endtask

    task automatic test_random();
        int hold_left;
        hold_left = 0;
        repeat (4000) begin
            @(negedge clk); checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL random_model got %h expected %h", obs_v, exp_v); end
            reset = ($urandom_range(0, 499) == 0);
            if (hold_left == 0) begin
                track = 3'($urandom_range(0, 7));
                hold_left = $urandom_range(1, 40);
            end else hold_left--;
            if ($urandom_range(0, 99) == 0) enable = ~enable;
            if (obstacle) obstacle = ($urandom_range(0, 3) != 0);
            else          obstacle = ($urandom_range(0, 149) == 0);
        end
        reset = 1'b0; obstacle = 1'b0;
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_ramp_clamp();
        test_reversal();
        test_estop();
        test_pwm_duty();
        enable = 1'b1;
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/car_motion_sequencer.md
Name: car_motion_sequencer

Overview:
Sequences the car's two drive motors from the 3-bit line-tracker decision code. Debounces the tracker code into an accepted motion command and maps it to per-wheel target speed and direction. Ramps each wheel's speed toward its target, forcing speed through zero before any direction reversal. Provides an obstacle emergency stop and drives the PWM and direction pins of the motor driver.

Parameters:
HOLD_CYCLES, 4, cycles a new tracker code must stay stable before it is accepted (>=1)
RAMP_DIV, 1000, clk cycles per ramp tick (>=1)
RAMP_STEP, 16, speed change per ramp tick
FAST, 10'd800, fast wheel speed (duty out of 1024)
SLOW, 10'd500, slow wheel speed

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  run request; low means controlled ramp-down
obstacle  in  1  emergency stop request from the distance sensor
track_state  in  3  tracker code: 0 STOP, 1 FORWARD, 2 BACK, 3 LEFT, 4 RIGHT, 5 STRONG_LEFT, 6 STRONG_RIGHT, 7 invalid
left_pwm / right_pwm  out  1  motor PWM
left_dir / right_dir  out  1  1=forward, 0=reverse
left_speed / right_speed  out  10  current ramped duty
cmd  out  3  accepted command
motion_state  out  2  0 IDLE, 1 RUN, 2 ESTOP
moving  out  1  high when either speed is nonzero (combinational from the speed registers)

Behaviour:
- Clock and reset: reset is synchronous, active-high; clock is clk. All registers update on posedge clk.
- Reset values:
  - speeds 0, dirs 1, cmd 0, candidate 0, hold counter 0, ramp prescaler 0, PWM counter 0.
  - pwm outputs 0, motion_state IDLE, moving 0.
- Debounce:
  - If track_state differs from the candidate register: candidate <= track_state, hold <= 0.
  - Otherwise hold increments, saturating at HOLD_CYCLES-1.
  - When registered hold == HOLD_CYCLES-1, cmd <= candidate.
  - A code first sampled at edge t appears on cmd at edge t+HOLD_CYCLES.
  - Code 7 is accepted as STOP.
- Target map (left, right), direction forward unless noted:
  - STOP: (0, 0)
  - FORWARD: (FAST, FAST)
  - BACK: (SLOW, SLOW), both reverse
  - LEFT: (SLOW, FAST)
  - RIGHT: (FAST, SLOW)
  - STRONG_LEFT: (0, FAST)
  - STRONG_RIGHT: (FAST, 0)
- Motion FSM, evaluated in priority order:
  - obstacle=1 -> ESTOP from any state.
  - ESTOP with obstacle=0 -> IDLE.
  - IDLE with enable=1 -> RUN.
  - RUN with enable=0 -> IDLE.
  - Targets are the mapped values only in RUN; they are 0 in IDLE and ESTOP.
- ESTOP forcing:
  - While in ESTOP, both speeds are forced to 0 on every edge, with no ramp.
  - The edge that enters ESTOP also zeroes the speeds, so speed is 0 one cycle after obstacle rises.
  - Dirs hold their values in ESTOP.
- Ramp:
  - The prescaler counts 0..RAMP_DIV-1; the tick is the cycle where the prescaler is at RAMP_DIV-1.
  - On a tick, each wheel is updated independently:
    - If the target direction differs from the current direction: with speed > 0, speed decreases by RAMP_STEP, clamped at 0; with speed == 0, dir <= target direction and speed is unchanged on that tick.
    - Otherwise speed moves toward target by RAMP_STEP, clamped exactly at target with no overshoot or underflow.
  - All speed arithmetic uses 11 bits internally before clamping.
- PWM:
  - A 10-bit free-running counter wraps from 1023 to 0.
  - pwm is registered as (counter < speed); speed 0 gives a constant-low output.
- Mid-ramp command change: the new target takes effect on the next tick; no restart of the prescaler.
- Reset mid-operation: all values return to their reset values on the next edge.

Test Plan:
- Reset defaults: assert reset 2 cycles -> speeds 0, dirs 1, pwm 0, cmd 0, motion_state 0, moving 0.
- Debounce: enable=1, track_state=1 for 3 cycles then 0 -> cmd stays 0. Hold 1 for 4 cycles -> cmd=1 exactly 4 edges after the first sample.
- Ramp clamp: RAMP_DIV=2, RAMP_STEP=16, FAST=40, FORWARD accepted -> left_speed goes 16, 32, 40 on successive ticks, then stays 40.
- Reversal: FORWARD at speed 800, then BACK accepted with RAMP_STEP=16 -> 50 down-ticks to 0, dir becomes 0 on the next tick, then ramps up to 500 with dir 0.
- Emergency stop: running at 800, obstacle=1 -> next edge speeds 0, motion_state 2, pwm low. Release obstacle -> IDLE, then RUN, ramping from 0.
- PWM duty: speed held at 256 -> pwm high for exactly 256 of every 1024 cycles. Speed 0 -> never high.
